// File: rtl/axi_lite_pkg.sv
// Shared types/constants for the AXI-Lite arbiter slice.
// Arbiter FSM states, response codes, grant encodings.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// 2-way round-robin picker, purely combinational.
// Ports: req[1:0], last (last granted index) -> one-hot gnt.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the master after the last-granted one wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = req;
    endcase
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master round-robin AXI-Lite arbiter, whole-transaction grants.
// Ports: clk, rst_n, m0/m1 AW/W/B/AR/R, slave-side o_s_*/i_s_*, o_grant.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_m0_awvalid,
  input  logic [ADDR_WIDTH-1:0]   i_m0_awaddr,
  output logic                    o_m0_awready,
  input  logic                    i_m0_wvalid,
  input  logic [STROBE_WIDTH-1:0] i_m0_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
  output logic                    o_m0_wready,
  output logic                    o_m0_bvalid,
  output logic [1:0]              o_m0_bresp,
  input  logic                    i_m0_bready,
  input  logic                    i_m0_arvalid,
  input  logic [ADDR_WIDTH-1:0]   i_m0_araddr,
  output logic                    o_m0_arready,
  output logic                    o_m0_rvalid,
  output logic [1:0]              o_m0_rresp,
  output logic [DATA_WIDTH-1:0]   o_m0_rdata,
  input  logic                    i_m0_rready,
  input  logic                    i_m1_awvalid,
  input  logic [ADDR_WIDTH-1:0]   i_m1_awaddr,
  output logic                    o_m1_awready,
  input  logic                    i_m1_wvalid,
  input  logic [STROBE_WIDTH-1:0] i_m1_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
  output logic                    o_m1_wready,
  output logic                    o_m1_bvalid,
  output logic [1:0]              o_m1_bresp,
  input  logic                    i_m1_bready,
  input  logic                    i_m1_arvalid,
  input  logic [ADDR_WIDTH-1:0]   i_m1_araddr,
  output logic                    o_m1_arready,
  output logic                    o_m1_rvalid,
  output logic [1:0]              o_m1_rresp,
  output logic [DATA_WIDTH-1:0]   o_m1_rdata,
  input  logic                    i_m1_rready,
  output logic                    o_s_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_s_awaddr,
  input  logic                    i_s_awready,
  output logic                    o_s_wvalid,
  output logic [STROBE_WIDTH-1:0] o_s_wstrb,
  output logic [DATA_WIDTH-1:0]   o_s_wdata,
  input  logic                    i_s_wready,
  input  logic                    i_s_bvalid,
  input  logic [1:0]              i_s_bresp,
  output logic                    o_s_bready,
  output logic                    o_s_arvalid,
  output logic [ADDR_WIDTH-1:0]   o_s_araddr,
  input  logic                    i_s_arready,
  input  logic                    i_s_rvalid,
  input  logic [1:0]              i_s_rresp,
  input  logic [DATA_WIDTH-1:0]   i_s_rdata,
  output logic                    o_s_rready,
  output logic [1:0]              o_grant
);

  state_t     state;
  logic       owner;
  logic       last;
  logic       aw_done;
  logic       w_done;
  logic [1:0] grant_q;
  logic [1:0] pick;

  logic in_aw, in_b, in_ar, in_r;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic awrdy, wrdy, bv, arrdy, rv;

  rr_pick2 u_pick (
    .req  ({i_m1_awvalid | i_m1_arvalid,
            i_m0_awvalid | i_m0_arvalid}),
    .last (last),
    .gnt  (pick)
  );

  assign in_aw = (state == WR_AW);
  assign in_b  = (state == WR_B);
  assign in_ar = (state == RD_AR);
  assign in_r  = (state == RD_R);

  // Payload muxes follow the owner; valids are gated by state.
  assign o_s_awaddr = owner ? i_m1_awaddr : i_m0_awaddr;
  assign o_s_wstrb  = owner ? i_m1_wstrb  : i_m0_wstrb;
  assign o_s_wdata  = owner ? i_m1_wdata  : i_m0_wdata;
  assign o_s_araddr = owner ? i_m1_araddr : i_m0_araddr;

  assign o_s_awvalid = in_aw & ~aw_done &
                       (owner ? i_m1_awvalid : i_m0_awvalid);
  assign o_s_wvalid  = in_aw & ~w_done &
                       (owner ? i_m1_wvalid : i_m0_wvalid);
  assign o_s_bready  = in_b &
                       (owner ? i_m1_bready : i_m0_bready);
  assign o_s_arvalid = in_ar &
                       (owner ? i_m1_arvalid : i_m0_arvalid);
  assign o_s_rready  = in_r &
                       (owner ? i_m1_rready : i_m0_rready);

  assign awrdy = in_aw & ~aw_done & i_s_awready;
  assign wrdy  = in_aw & ~w_done & i_s_wready;
  assign bv    = in_b & i_s_bvalid;
  assign arrdy = in_ar & i_s_arready;
  assign rv    = in_r & i_s_rvalid;

  assign o_m0_awready = awrdy & ~owner;
  assign o_m1_awready = awrdy & owner;
  assign o_m0_wready  = wrdy & ~owner;
  assign o_m1_wready  = wrdy & owner;
  assign o_m0_bvalid  = bv & ~owner;
  assign o_m1_bvalid  = bv & owner;
  assign o_m0_arready = arrdy & ~owner;
  assign o_m1_arready = arrdy & owner;
  assign o_m0_rvalid  = rv & ~owner;
  assign o_m1_rvalid  = rv & owner;

  assign o_m0_bresp = i_s_bresp;
  assign o_m1_bresp = i_s_bresp;
  assign o_m0_rresp = i_s_rresp;
  assign o_m1_rresp = i_s_rresp;
  assign o_m0_rdata = i_s_rdata;
  assign o_m1_rdata = i_s_rdata;

  assign aw_hs = o_s_awvalid & i_s_awready;
  assign w_hs  = o_s_wvalid & i_s_wready;
  assign b_hs  = o_s_bready & i_s_bvalid;
  assign ar_hs = o_s_arvalid & i_s_arready;
  assign r_hs  = o_s_rready & i_s_rvalid;

  assign o_grant = grant_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      grant_q <= GRANT_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (|pick) begin
            owner   <= pick[1];
            grant_q <= pick;
            // Write wins over read within the chosen master.
            state <= (pick[1] ? i_m1_awvalid : i_m0_awvalid)
                     ? WR_AW : RD_AR;
          end
        end
        WR_AW: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WR_B;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end
        WR_B: begin
          if (b_hs) begin
            state   <= IDLE;
            last    <= owner;
            grant_q <= GRANT_NONE;
          end
        end
        RD_AR: begin
          if (ar_hs) state <= RD_R;
        end
        RD_R: begin
          if (r_hs) begin
            state   <= IDLE;
            last    <= owner;
            grant_q <= GRANT_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
